// File: rtl/uart_tx_buffered_param.sv
// Buffered UART transmitter: toggle-request push into a FIFO, framed serial output
// with optional parity, 1 or 2 stop bits, overflow flag and a bit-boundary tick.
module uart_tx_buffered_param #(
    parameter int DATA_BITS    = 8,
    parameter int FIFO_AW      = 4,
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_transmission,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 overflow_clear,
    output logic                 tx,
    output logic                 busy,
    output logic                 fifo_full,
    output logic [FIFO_AW:0]     fifo_count,
    output logic                 overflow,
    output logic                 bit_tick
);

    localparam int   DEPTH  = 2 ** FIFO_AW;
    localparam int   BW     = $clog2(CLKS_PER_BIT);
    localparam int   IW     = $clog2(DATA_BITS);
    localparam logic PAR_EN = (PARITY_MODE == 1) || (PARITY_MODE == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               r_state, w_state_next;
    logic [BW-1:0]        r_baud_cnt;
    logic [IW-1:0]        r_bit_idx;
    logic                 r_stop_cnt;
    logic [DATA_BITS-1:0] r_shift, w_shift_next, w_head;
    logic [DATA_BITS-1:0] r_mem [DEPTH];
    logic [FIFO_AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [FIFO_AW:0]     r_count;
    logic                 r_tx, r_parity, r_overflow, r_start_prev, r_settle;
    logic                 w_tick, w_pop, w_toggle, w_full, w_push, w_drop, w_tx_next;

    assign w_full   = (r_count == (FIFO_AW+1)'(DEPTH));
    assign w_tick   = (r_state != S_IDLE) && (r_baud_cnt == BW'(CLKS_PER_BIT - 1));
    assign w_pop    = (r_state == S_IDLE) && (r_count != '0);
    // settle blocks the first edge after reset so a high toggle level is not a request
    assign w_toggle = !r_settle && (start_transmission != r_start_prev);
    assign w_push   = w_toggle && (!w_full || w_pop);
    assign w_drop   = w_toggle && w_full && !w_pop;
    assign w_head   = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_start_prev <= 1'b0;
            r_settle     <= 1'b1;
        end else begin
            r_settle     <= 1'b0;
            r_start_prev <= start_transmission;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop)              r_overflow <= 1'b1;
            else if (overflow_clear) r_overflow <= 1'b0;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_shift_next = r_shift;
        w_tx_next    = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (w_pop) begin
                    w_state_next = S_START;
                    w_shift_next = w_head;
                end
            end
            S_START: begin
                if (w_tick) w_state_next = S_DATA;
            end
            S_DATA: begin
                if (w_tick) begin
                    w_shift_next = r_shift >> 1;
                    if (r_bit_idx == IW'(DATA_BITS - 1)) begin
                        w_state_next = PAR_EN ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (w_tick) w_state_next = S_STOP;
            end
            S_STOP: begin
                if (w_tick && (r_stop_cnt == 1'(STOP_BITS - 1))) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
        // tx is registered from the next state so the line changes exactly on bit edges
        case (w_state_next)
            S_START:  w_tx_next = 1'b0;
            S_DATA:   w_tx_next = w_shift_next[0];
            S_PARITY: w_tx_next = r_parity;
            default:  w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_stop_cnt <= 1'b0;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_shift <= w_shift_next;
            r_tx    <= w_tx_next;
            if (r_state == S_IDLE || w_tick) r_baud_cnt <= '0;
            else                             r_baud_cnt <= r_baud_cnt + 1'b1;
            if (w_pop) begin
                r_bit_idx <= '0;
                r_parity  <= (PARITY_MODE == 2) ? ~(^w_head) : (^w_head);
            end else if (r_state == S_DATA && w_tick) begin
                r_bit_idx <= r_bit_idx + 1'b1;
            end
            if (r_state != S_STOP) r_stop_cnt <= 1'b0;
            else if (w_tick)       r_stop_cnt <= r_stop_cnt + 1'b1;
        end
    end

    assign tx         = r_tx;
    assign busy       = (r_state != S_IDLE) || (r_count != '0);
    assign fifo_full  = w_full;
    assign fifo_count = r_count;
    assign overflow   = r_overflow;
    assign bit_tick   = w_tick;

endmodule

// File: doc/uart_tx_buffered_param.md
Name: uart_tx_buffered_param

Overview:
- Parametrised successor to the buffered UART transmitter core.
- Accepts bytes by a toggle-style request, queues them in an internal FIFO and serialises them on tx.
- Configurable data width, FIFO depth, baud divisor, parity mode and stop-bit count; adds overflow detection, occupancy reporting and a baud-rate self-check output.
- Sits between the classifier result logic and the board UART pin.

Parameters:
- DATA_BITS, 8, payload bits per frame, legal range 5..9
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW words
- CLKS_PER_BIT, 434, clock cycles per serial bit, minimum 2
- PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd
- STOP_BITS, 1, stop bits per frame, 1 or 2

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous active-low reset
- start_transmission  in  1  toggle request; each level change pushes data_in once
- data_in  in  DATA_BITS  word to queue, sampled on the push edge
- overflow_clear  in  1  synchronous pulse, clears overflow
- tx  out  1  serial line, idle high
- busy  out  1  high while FIFO non-empty or a frame is in flight
- fifo_full  out  1  FIFO holds 2**FIFO_AW words
- fifo_count  out  FIFO_AW+1  current occupancy
- overflow  out  1  sticky; a push was dropped because the FIFO was full
- bit_tick  out  1  one-cycle pulse at each serial bit boundary, for bench baud checks

Behaviour:
- Reset (reset=0, asynchronous): tx=1, busy=0, fifo_full=0, fifo_count=0, overflow=0, bit_tick=0.
  - Also clears the FSM to IDLE, the FIFO pointers, the baud counter and start_prev.
  - A settle flag is set by reset.
- Reset mid-frame: the frame is aborted, tx goes high immediately, and queued words are discarded.
- Reset release and settle:
  - On the first clock edge after release, start_prev loads start_transmission, no push occurs, and the settle flag clears.
  - This prevents a spurious push when the toggle is high at release.
- Push detection:
  - At each edge with the settle flag clear: toggle_seen = (start_transmission != start_prev), and start_prev <= start_transmission.
  - If toggle_seen and the FIFO is not full, data_in is written at that edge and fifo_count increments at that edge.
  - If toggle_seen and the FIFO is full, the word is dropped and overflow <= 1.
- Pop:
  - Occurs only in IDLE when fifo_count > 0.
  - The head word loads the shift register at that edge, and the FSM enters START.
  - There is no bypass: a push into an empty FIFO is transmitted starting the cycle after its write edge.
- Simultaneous push and pop at the same edge:
  - Both are accepted and fifo_count is unchanged.
  - At full, the pop frees a slot, so the push is accepted and overflow is not set.
- overflow priority: a set (dropped push) takes priority over overflow_clear in the same cycle.
- Pointers: wrap modulo 2**FIFO_AW. fifo_full = (fifo_count == 2**FIFO_AW).
- FSM states: IDLE -> START -> DATA -> PARITY (skipped when PARITY_MODE=0) -> STOP -> IDLE.
  - IDLE with FIFO empty: remains in IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 in every non-IDLE state. bit_tick=1 on the cycle where the count equals CLKS_PER_BIT-1; that is the state/bit-advance edge.
- Per-state line behaviour:
  - START: tx=0 for one bit.
  - DATA: tx = shift_reg[0], LSB first; shift right on each bit_tick; a bit index counts 0..DATA_BITS-1.
  - PARITY: tx = XOR of the data bits for even, or its inverse for odd.
  - STOP: tx=1 for STOP_BITS bits.
- Back-to-back frames: at the final STOP bit_tick the FSM returns to IDLE. If the FIFO is non-empty, the next pop occurs on the following edge, giving exactly one extra idle-high clock between frames.
- Frame length: (1 + DATA_BITS + (PARITY_MODE != 0) + STOP_BITS) * CLKS_PER_BIT cycles, plus 1 IDLE cycle.
- tx is registered (glitch-free). busy = (state != IDLE) || (fifo_count != 0).
- Undefined PARITY_MODE value 3: treated as none.

Test Plan:
- Directed bench configuration: DATA_BITS=8, FIFO_AW=2, CLKS_PER_BIT=4, PARITY_MODE=0, STOP_BITS=1, except where noted.
- Reset with start_transmission=1:
  - Release reset with start_transmission held at 1 → no push; fifo_count=0, tx=1, busy=0 for 50 cycles.
- Single byte 0x0A:
  - Toggle once → fifo_count=1 at the push edge.
  - tx sequence per 4-cycle bit: 0, 0,1,0,1,0,0,0,0, 1 (start, data LSB first, stop).
  - busy falls 40 cycles after the pop.
  - bit_tick pulses every 4 cycles.
- Burst and overflow:
  - Toggle 6 times on consecutive cycles with data 1..6.
  - Word 1 pops; words 2..5 fill the FIFO; word 6 is dropped and overflow=1.
  - Output frames are 1,2,3,4,5 with one idle clock between frames.
  - overflow_clear then clears the flag.
- Push and pop at full:
  - Fill the FIFO to 4 while a frame is in flight.
  - Toggle at the exact IDLE pop edge → accepted, fifo_count stays 4, overflow=0.
- Parity modes:
  - PARITY_MODE=1, data 0x0D → parity bit 1.
  - PARITY_MODE=2, data 0x0D → parity bit 0.
  - STOP_BITS=2 → stop high for 8 cycles.
  - DATA_BITS=7, data 0x55 → 7 data bits only.
- Reset mid-frame:
  - Assert reset at the 3rd data bit → tx=1 immediately, fifo_count=0, busy=0.
  - After release, a new toggle with 0xA5 is transmitted correctly.
